// File: rtl/db_spi_sequencer_pkg.sv
// Shared types and constants for the SPI command sequencer.
// Included first by every file of the block.
package db_spi_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DIV,
    S_WR_CFG,
    S_WR_DATA,
    S_GAP,
    S_ARM,
    S_WAIT_RB,
    S_RESP
  } state_e;

  localparam logic [1:0] OFF_DIV  = 2'd0;
  localparam logic [1:0] OFF_CFG  = 2'd1;
  localparam logic [1:0] OFF_DATA = 2'd2;

  localparam int ARM_LEN = 2;

  function automatic state_e wr_state(input logic [1:0] off);
    state_e s;
    case (off)
      OFF_DIV: s = S_WR_DIV;
      OFF_CFG: s = S_WR_CFG;
      default: s = S_WR_DATA;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/db_spi_seq_timer.sv
// Clearable 16-bit up-counter with a terminal flag.
// Shared by the inter-write gap and the readback wait.
module db_spi_seq_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] lim_i,
  output logic        term_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else if (load_i) begin
      cnt_q <= 16'd0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign term_o = (cnt_q == lim_i);

endmodule

// File: rtl/db_spi_sequencer.sv
// Turns SPI command beats into settings-bus writes and
// returns one readback response per transaction.
module db_spi_sequencer
  import db_spi_sequencer_pkg::*;
#(
  parameter logic [7:0] BASE        = 8'd8,
  parameter logic [7:0] RB_SPI_ADDR = 8'd0,
  parameter int         TIMEOUT     = 65535,
  parameter int         SET_GAP     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] clk_div,
  input  logic [63:0] cmd_tdata,
  input  logic        cmd_tvalid,
  output logic        cmd_tready,
  output logic [31:0] resp_tdata,
  output logic        resp_tuser,
  output logic        resp_tvalid,
  input  logic        resp_tready,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic [7:0]  rb_addr,
  input  logic        rb_stb,
  input  logic [63:0] rb_data,
  output logic        busy
);

  localparam logic [15:0] GAP_LIM =
    16'(SET_GAP > 0 ? SET_GAP - 1 : 0);
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic        cmd_tready_q;
  logic        resp_tvalid_q;
  logic        resp_tuser_q;
  logic [31:0] resp_tdata_q;
  logic        busy_q;
  logic        set_stb_q;
  logic [7:0]  set_addr_q;
  logic [31:0] set_data_q;
  logic [31:0] cfg_lat_q;
  logic [31:0] data_lat_q;
  logic [15:0] div_q;
  logic [31:0] cfg_q;
  logic        div_valid_q;
  logic        cfg_valid_q;
  logic [1:0]  last_q;
  logic [1:0]  arm_q;

  logic        is_idle;
  logic        is_wr;
  logic        accept;
  logic        adv;
  logic        nxt_wr;
  logic [1:0]  nxt_off;
  logic [31:0] nxt_data;
  logic [31:0] cfg_src;
  logic [31:0] data_src;
  logic        tmr_load;
  logic        tmr_term;
  logic [15:0] tmr_lim;
  logic        unused_rb;

  assign unused_rb = ^rb_data[63:32];

  assign is_idle  = (state_q == S_IDLE);
  assign is_wr    = (state_q == S_WR_DIV) ||
                    (state_q == S_WR_CFG) ||
                    (state_q == S_WR_DATA);
  assign accept   = is_idle && cmd_tready_q && cmd_tvalid;
  assign cfg_src  = is_idle ? cmd_tdata[63:32] : cfg_lat_q;
  assign data_src = is_idle ? cmd_tdata[31:0] : data_lat_q;
  assign adv      = accept ||
                    (is_wr && (SET_GAP == 0)) ||
                    ((state_q == S_GAP) && tmr_term);

  // Next write in the div -> cfg -> data chain, skipping cached ones
  always_comb begin
    nxt_wr  = 1'b1;
    nxt_off = OFF_DATA;
    if (is_idle) begin
      if (!div_valid_q || clk_div != div_q) begin
        nxt_off = OFF_DIV;
      end else if (!cfg_valid_q || cfg_src != cfg_q) begin
        nxt_off = OFF_CFG;
      end
    end else if (last_q == OFF_DIV) begin
      if (!cfg_valid_q || cfg_src != cfg_q) begin
        nxt_off = OFF_CFG;
      end
    end else if (last_q == OFF_DATA) begin
      nxt_wr = 1'b0;
    end
  end

  always_comb begin
    nxt_data = data_src;
    case (nxt_off)
      OFF_DIV: nxt_data = {16'h0000, clk_div};
      OFF_CFG: nxt_data = cfg_src;
      default: nxt_data = data_src;
    endcase
  end

  assign tmr_load = !((state_q == S_GAP) ||
                      (state_q == S_WAIT_RB));
  assign tmr_lim  = (state_q == S_GAP) ? GAP_LIM : TO_LIM;

  db_spi_seq_timer u_timer (
    .clk    (clk),
    .rst_n  (reset_n),
    .load_i (tmr_load),
    .en_i   (!tmr_load),
    .lim_i  (tmr_lim),
    .term_o (tmr_term)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cmd_tready_q  <= 1'b0;
      resp_tvalid_q <= 1'b0;
      resp_tuser_q  <= 1'b0;
      resp_tdata_q  <= 32'd0;
      busy_q        <= 1'b0;
      set_stb_q     <= 1'b0;
      set_addr_q    <= 8'd0;
      set_data_q    <= 32'd0;
      cfg_lat_q     <= 32'd0;
      data_lat_q    <= 32'd0;
      div_q         <= 16'd0;
      cfg_q         <= 32'd0;
      div_valid_q   <= 1'b0;
      cfg_valid_q   <= 1'b0;
      last_q        <= OFF_DIV;
      arm_q         <= 2'd0;
    end else begin
      set_stb_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            cmd_tready_q <= 1'b0;
            busy_q       <= 1'b1;
            cfg_lat_q    <= cmd_tdata[63:32];
            data_lat_q   <= cmd_tdata[31:0];
          end else begin
            cmd_tready_q <= 1'b1;
          end
        end
        S_WR_DIV, S_WR_CFG, S_WR_DATA: begin
          if (SET_GAP != 0) state_q <= S_GAP;
        end
        S_GAP: begin
        end
        S_ARM: begin
          if (arm_q == 2'(ARM_LEN - 1)) begin
            state_q <= S_WAIT_RB;
          end else begin
            arm_q <= arm_q + 2'd1;
          end
        end
        S_WAIT_RB: begin
          if (rb_stb) begin
            resp_tdata_q  <= rb_data[31:0];
            resp_tuser_q  <= 1'b0;
            resp_tvalid_q <= 1'b1;
            state_q       <= S_RESP;
          end else if (tmr_term) begin
            // Downstream state unknown: force full rewrite next time
            resp_tdata_q  <= 32'd0;
            resp_tuser_q  <= 1'b1;
            resp_tvalid_q <= 1'b1;
            div_valid_q   <= 1'b0;
            cfg_valid_q   <= 1'b0;
            state_q       <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_tready) begin
            resp_tvalid_q <= 1'b0;
            busy_q        <= 1'b0;
            cmd_tready_q  <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (adv) begin
        if (nxt_wr) begin
          state_q    <= wr_state(nxt_off);
          set_stb_q  <= 1'b1;
          set_addr_q <= BASE + {6'd0, nxt_off};
          set_data_q <= nxt_data;
          last_q     <= nxt_off;
          if (nxt_off == OFF_DIV) begin
            div_q       <= clk_div;
            div_valid_q <= 1'b1;
          end
          if (nxt_off == OFF_CFG) begin
            cfg_q       <= cfg_src;
            cfg_valid_q <= 1'b1;
          end
        end else begin
          state_q <= S_ARM;
          arm_q   <= 2'd0;
        end
      end
    end
  end

  assign cmd_tready  = cmd_tready_q;
  assign resp_tdata  = resp_tdata_q;
  assign resp_tuser  = resp_tuser_q;
  assign resp_tvalid = resp_tvalid_q;
  assign set_stb     = set_stb_q;
  assign set_addr    = set_addr_q;
  assign set_data    = set_data_q;
  assign rb_addr     = RB_SPI_ADDR;
  assign busy        = busy_q;

endmodule

// File: tb/tb_db_spi_sequencer.sv
// Directed bench for db_spi_sequencer: vector table plus
// hand sequences for backpressure and mid-flight reset.
module tb_db_spi_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] clk_div;
  logic [63:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [31:0] resp_tdata;
  logic        resp_tuser;
  logic        resp_tvalid;
  logic        resp_tready;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [7:0]  rb_addr;
  logic        rb_stb;
  logic [63:0] rb_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  int low_len = 0;
  int low_cnt = 0;
  bit stuck   = 1'b0;

  logic [39:0] wq[$];

  always #5 clk = ~clk;

  db_spi_sequencer #(
    .BASE        (8'd8),
    .RB_SPI_ADDR (8'd0),
    .TIMEOUT     (16),
    .SET_GAP     (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_div     (clk_div),
    .cmd_tdata   (cmd_tdata),
    .cmd_tvalid  (cmd_tvalid),
    .cmd_tready  (cmd_tready),
    .resp_tdata  (resp_tdata),
    .resp_tuser  (resp_tuser),
    .resp_tvalid (resp_tvalid),
    .resp_tready (resp_tready),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .rb_addr     (rb_addr),
    .rb_stb      (rb_stb),
    .rb_data     (rb_data),
    .busy        (busy)
  );

  // Downstream model: done flag drops one cycle after the trigger
  always @(posedge clk) begin
    bit trig;
    trig = set_stb && (set_addr == 8'd10);
    #1;
    if (trig) low_cnt = low_len;
    if (low_cnt > 0) begin
      rb_stb  = 1'b0;
      low_cnt = low_cnt - 1;
    end else begin
      rb_stb = !stuck;
    end
  end

  always @(negedge clk) begin
    if (set_stb) wq.push_back({set_addr, set_data});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic check_writes(input string tag,
                              input logic [2:0] mask,
                              input logic [15:0] div,
                              input logic [31:0] cfg,
                              input logic [31:0] dat);
    logic [39:0] ex[$];
    if (mask[0]) ex.push_back({8'd8, 16'h0000, div});
    if (mask[1]) ex.push_back({8'd9, cfg});
    if (mask[2]) ex.push_back({8'd10, dat});
    chk({tag, "_nwr"}, 64'(wq.size()), 64'(ex.size()));
    for (int i = 0; i < ex.size() && i < wq.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 64'(wq[i]), 64'(ex[i]));
  endtask

  task automatic run_cmd(input logic [31:0] cfg,
                         input logic [31:0] dat,
                         input logic [15:0] div,
                         input int low, input bit stk,
                         input logic [63:0] rbd,
                         input int hold,
                         output int lat,
                         output logic [31:0] rd,
                         output logic ru,
                         output bit ok);
    int n;
    ok = 1'b1;
    lat = 0;
    rd = '0;
    ru = 1'b0;
    clk_div = div;
    low_len = low;
    stuck = stk;
    rb_data = rbd;
    wq.delete();
    @(negedge clk);
    cmd_tdata  = {cfg, dat};
    cmd_tvalid = 1'b1;
    n = 0;
    while (!cmd_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_tready) begin
      chk("accept_timeout", 64'(cmd_tready), 64'd1);
      cmd_tvalid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_tvalid = 1'b0;
    while (!resp_tvalid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_tvalid) begin
      chk("resp_timeout", 64'(resp_tvalid), 64'd1);
      ok = 1'b0;
      return;
    end
    rd = resp_tdata;
    ru = resp_tuser;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_tvalid), 64'd1);
      chk("hold_data", 64'(resp_tdata), 64'(rd));
      chk("hold_cmd_tready", 64'(cmd_tready), 64'd0);
    end
    resp_tready = 1'b1;
    @(negedge clk);
    resp_tready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] cfg;
    logic [31:0] dat;
    logic [15:0] div;
    int          low;
    bit          stk;
    logic [63:0] rbd;
    logic [2:0]  wmask;
    int          lat;
    logic [31:0] edata;
    logic        euser;
  } vec_t;

  localparam int NV = 10;
  vec_t v[NV];

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        ru;
    bit          ok;
    bit          seen;
    int          n;

    v[0] = '{32'h0000_1818, 32'hA5A5_0000, 16'd4, 10, 1'b0,
             64'hFFFF_0000_DEAD_BEEF, 3'b111, 16,
             32'hDEAD_BEEF, 1'b0};
    v[1] = '{32'h0000_1818, 32'hA5A5_0000, 16'd4, 0, 1'b0,
             64'h1234_5678_0000_C0DE, 3'b100, 5,
             32'h0000_C0DE, 1'b0};
    v[2] = '{32'h0000_1818, 32'h1234_5678, 16'd4, 2, 1'b0,
             64'h0000_0000_0000_0042, 3'b100, 5,
             32'h0000_0042, 1'b0};
    v[3] = '{32'h0000_2020, 32'h0000_0001, 16'd4, 0, 1'b0,
             64'h0000_0000_0000_AAAA, 3'b110, 7,
             32'h0000_AAAA, 1'b0};
    v[4] = '{32'h0000_2020, 32'h0000_0002, 16'd8, 0, 1'b0,
             64'h0000_0000_0000_5555, 3'b101, 7,
             32'h0000_5555, 1'b0};
    v[5] = '{32'h0000_2020, 32'h0000_0003, 16'd8, 0, 1'b1,
             64'h0000_0000_0000_0BAD, 3'b100, 20,
             32'h0000_0000, 1'b1};
    v[6] = '{32'h0000_2020, 32'h0000_0004, 16'd8, 0, 1'b0,
             64'h0000_0000_0000_0066, 3'b111, 9,
             32'h0000_0066, 1'b0};
    v[7] = '{32'h0000_2020, 32'h0000_0005, 16'd8, 18, 1'b0,
             64'h0000_0000_0000_0077, 3'b100, 20,
             32'h0000_0077, 1'b0};
    v[8] = '{32'h0000_2020, 32'h0000_0006, 16'd8, 19, 1'b0,
             64'h0000_0000_0000_0088, 3'b100, 20,
             32'h0000_0000, 1'b1};
    v[9] = '{32'h0000_2020, 32'h0000_0007, 16'd8, 0, 1'b0,
             64'h0000_0000_0000_0099, 3'b111, 9,
             32'h0000_0099, 1'b0};

    reset_n     = 1'b0;
    clk_div     = 16'd0;
    cmd_tdata   = '0;
    cmd_tvalid  = 1'b0;
    resp_tready = 1'b0;
    rb_data     = '0;
    rb_stb      = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_set_stb", 64'(set_stb), 64'd0);
    chk("rst_set_addr", 64'(set_addr), 64'd0);
    chk("rst_set_data", 64'(set_data), 64'd0);
    chk("rst_cmd_tready", 64'(cmd_tready), 64'd0);
    chk("rst_resp_tvalid", 64'(resp_tvalid), 64'd0);
    chk("rst_resp_tdata", 64'(resp_tdata), 64'd0);
    chk("rst_resp_tuser", 64'(resp_tuser), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rb_addr", 64'(rb_addr), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_cmd(v[i].cfg, v[i].dat, v[i].div, v[i].low, v[i].stk,
              v[i].rbd, 0, lat, rd, ru, ok);
      if (ok) begin
        chk($sformatf("v%0d_lat", i), 64'(lat), 64'(v[i].lat));
        chk($sformatf("v%0d_data", i), 64'(rd), 64'(v[i].edata));
        chk($sformatf("v%0d_user", i), 64'(ru), 64'(v[i].euser));
        check_writes($sformatf("v%0d", i), v[i].wmask, v[i].div,
                     v[i].cfg, v[i].dat);
      end
    end

    // Response held off for 20 cycles
    run_cmd(32'h0000_2020, 32'h0000_0008, 16'd8, 0, 1'b0,
            64'h0000_0000_0BB0_0BB0, 20, lat, rd, ru, ok);
    if (ok) begin
      chk("bp_lat", 64'(lat), 64'd5);
      chk("bp_data", 64'(rd), 64'h0BB0_0BB0);
      chk("bp_user", 64'(ru), 64'd0);
      check_writes("bp", 3'b100, 16'd8, 32'h0000_2020,
                   32'h0000_0008);
    end

    // Reset while waiting on readback
    clk_div = 16'd8;
    stuck   = 1'b1;
    low_len = 0;
    @(negedge clk);
    cmd_tdata  = {32'h0000_2020, 32'h0000_0009};
    cmd_tvalid = 1'b1;
    n = 0;
    while (!cmd_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mr_accept", 64'(cmd_tready), 64'd1);
    @(negedge clk);
    cmd_tvalid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mr_busy_before", 64'(busy), 64'd1);
    chk("mr_addr_before", 64'(set_addr), 64'd10);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_set_stb", 64'(set_stb), 64'd0);
    chk("mr_set_addr", 64'(set_addr), 64'd0);
    chk("mr_set_data", 64'(set_data), 64'd0);
    chk("mr_cmd_tready", 64'(cmd_tready), 64'd0);
    chk("mr_resp_tvalid", 64'(resp_tvalid), 64'd0);
    chk("mr_resp_tdata", 64'(resp_tdata), 64'd0);
    chk("mr_resp_tuser", 64'(resp_tuser), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stuck   = 1'b0;
    seen    = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (resp_tvalid) seen = 1'b1;
    end
    chk("mr_no_resp", 64'(seen), 64'd0);
    run_cmd(32'h0000_2020, 32'h0000_000A, 16'd8, 0, 1'b0,
            64'h0000_0000_0000_00AB, 0, lat, rd, ru, ok);
    if (ok) begin
      chk("mr_lat", 64'(lat), 64'd9);
      chk("mr_data", 64'(rd), 64'h0000_00AB);
      chk("mr_user", 64'(ru), 64'd0);
      check_writes("mr", 3'b111, 16'd8, 32'h0000_2020,
                   32'h0000_000A);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
